// File: rtl/ysyx_25040101_srcb_stage_pkg.sv
// Shared encodings for the ALU operand-B source select and the hard-wired zero register.
package ysyx_25040101_srcb_stage_pkg;

  typedef enum logic [1:0] {
    SRCB_RS2 = 2'd0,
    SRCB_IMM = 2'd1,
    SRCB_INC = 2'd2,
    SRCB_PC  = 2'd3
  } srcb_sel_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/ysyx_25040101_srcb_stage_byp_resolve.sv
// Forwarding resolver: finds the lowest-index bypass channel writing rs2 and reports
// whether that producer's data is still outstanding.
module ysyx_25040101_byp_resolve
  import ysyx_25040101_srcb_stage_pkg::*;
#(
  parameter int unsigned NR_BYP = 2,
  parameter int unsigned AW     = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic [AW-1:0]          rs2_addr_i,
  input  logic [NR_BYP-1:0]      byp_valid_i,
  input  logic [NR_BYP-1:0]      byp_pending_i,
  input  logic [NR_BYP*AW-1:0]   byp_addr_i,
  input  logic [XLEN*NR_BYP-1:0] byp_data_i,
  output logic                   hit_c_o,
  output logic                   pending_c_o,
  output logic [XLEN-1:0]        data_c_o
);

  // Walk from the oldest channel to the youngest so the lowest matching index wins.
  always_comb begin
    hit_c_o     = 1'b0;
    pending_c_o = 1'b0;
    data_c_o    = '0;
    for (int unsigned i = 0; i < NR_BYP; i++) begin
      if (byp_valid_i[NR_BYP-1-i] &&
          byp_addr_i[(NR_BYP-1-i)*AW +: AW] == rs2_addr_i &&
          rs2_addr_i != AW'(ZERO_REG)) begin
        hit_c_o     = 1'b1;
        pending_c_o = byp_pending_i[NR_BYP-1-i];
        data_c_o    = byp_data_i[(NR_BYP-1-i)*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_25040101_srcb_stage.sv
// ALU operand-B stage: source select with register forwarding, load-use stall and a
// single-entry valid/ready output slot feeding execute.
module ysyx_25040101_srcb_stage
  import ysyx_25040101_srcb_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NR_BYP = 2,
  parameter int unsigned INC    = 4,
  parameter int unsigned AW     = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             sel_i,
  input  logic [AW-1:0]          rs2_addr_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [NR_BYP-1:0]      byp_valid_i,
  input  logic [NR_BYP-1:0]      byp_pending_i,
  input  logic [NR_BYP*AW-1:0]   byp_addr_i,
  input  logic [XLEN*NR_BYP-1:0] byp_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        srcb_data_o,
  output logic                   fwd_hit_o
);

  if (XLEN < 32) begin : g_inc_chk
    if ((INC >> XLEN) != 0) begin : g_inc_err
      $error("INC does not fit in XLEN");
    end
  end

  logic            byp_hit_c;
  logic            byp_pending_c;
  logic [XLEN-1:0] byp_data_c;

  ysyx_25040101_byp_resolve #(
    .NR_BYP (NR_BYP),
    .AW     (AW),
    .XLEN   (XLEN)
  ) u_byp_resolve (
    .rs2_addr_i    (rs2_addr_i),
    .byp_valid_i   (byp_valid_i),
    .byp_pending_i (byp_pending_i),
    .byp_addr_i    (byp_addr_i),
    .byp_data_i    (byp_data_i),
    .hit_c_o       (byp_hit_c),
    .pending_c_o   (byp_pending_c),
    .data_c_o      (byp_data_c)
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            hit_q, hit_d;
  logic            is_rs2_c;
  logic            stall_c;
  logic            accept_c;
  logic [XLEN-1:0] operand_c;

  // Operand mux; bypass only participates for register sources.
  always_comb begin
    is_rs2_c  = (srcb_sel_e'(sel_i) == SRCB_RS2);
    operand_c = rs2_data_i;
    case (srcb_sel_e'(sel_i))
      SRCB_RS2: operand_c = byp_hit_c ? byp_data_c : rs2_data_i;
      SRCB_IMM: operand_c = imm_i;
      SRCB_INC: operand_c = XLEN'(INC);
      SRCB_PC:  operand_c = pc_i;
      default:  operand_c = rs2_data_i;
    endcase
  end

  // Handshake and slot next-state; flush wins over load and hold.
  always_comb begin
    stall_c    = is_rs2_c && byp_hit_c && byp_pending_c;
    in_ready_o = !reset && !stall_c && (!valid_q || out_ready_i);
    accept_c   = in_valid_i && in_ready_o && !flush_i;
    valid_d    = valid_q;
    data_d     = data_q;
    hit_d      = hit_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d = 1'b1;
      data_d  = operand_c;
      hit_d   = is_rs2_c && byp_hit_c;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
    end
  end

  assign out_valid_o = valid_q;
  assign srcb_data_o = data_q;
  assign fwd_hit_o   = hit_q;

endmodule

// File: tb/tb_ysyx_25040101_srcb_stage.sv
// Bench for the operand-B stage: vector table plus hand sequences for stall, backpressure,
// flush and reset, with a queue of expected outputs checked as execute consumes them.
module tb_ysyx_25040101_srcb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  sel_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [31:0] pc_i;
  logic [1:0]  byp_valid_i;
  logic [1:0]  byp_pending_i;
  logic [9:0]  byp_addr_i;
  logic [63:0] byp_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] srcb_data_o;
  logic        fwd_hit_o;

  ysyx_25040101_srcb_stage dut (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .sel_i         (sel_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs2_data_i    (rs2_data_i),
    .imm_i         (imm_i),
    .pc_i          (pc_i),
    .byp_valid_i   (byp_valid_i),
    .byp_pending_i (byp_pending_i),
    .byp_addr_i    (byp_addr_i),
    .byp_data_i    (byp_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .srcb_data_o   (srcb_data_o),
    .fwd_hit_o     (fwd_hit_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] rf;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [1:0]  bv;
    logic [1:0]  bp;
    logic [9:0]  ba;
    logic [63:0] bd;
    logic [31:0] exp_d;
    logic        exp_h;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        h;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Execute-side monitor: compare the slot against the oldest expectation, retire on consume.
  always @(negedge clock) begin
    if (mon_en && out_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got data %0h with no expected entry", srcb_data_o);
      end else begin
        check("mon_data", 64'(srcb_data_o), 64'(sb_q[0].d));
        check("mon_hit", 64'(fwd_hit_o), 64'(sb_q[0].h));
        if (out_ready_i) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input vec_t v);
    in_valid_i    = 1'b1;
    sel_i         = v.sel;
    rs2_addr_i    = v.addr;
    rs2_data_i    = v.rf;
    imm_i         = v.imm;
    pc_i          = v.pc;
    byp_valid_i   = v.bv;
    byp_pending_i = v.bp;
    byp_addr_i    = v.ba;
    byp_data_i    = v.bd;
  endtask

  // Drive one request for a cycle, check ready, and queue the result if it is taken.
  task automatic issue(input string name, input vec_t v, input logic exp_ready);
    step();
    set_req(v);
    @(negedge clock);
    check(name, 64'(in_ready_o), 64'(exp_ready));
    if (exp_ready && !flush_i) sb_q.push_back('{d: v.exp_d, h: v.exp_h});
  endtask

  task automatic idle();
    step();
    in_valid_i = 1'b0;
  endtask

  vec_t v;

  initial begin
    vecs[0] = '{2'd1, 5'd0, 32'h0,  32'hFFFF_F800, 32'h0, 2'b00, 2'b00, 10'h0, 64'h0, 32'hFFFF_F800, 1'b0};
    vecs[1] = '{2'd2, 5'd0, 32'h0,  32'h0,  32'h0,         2'b00, 2'b00, 10'h0, 64'h0, 32'h4, 1'b0};
    vecs[2] = '{2'd3, 5'd0, 32'h0,  32'h0,  32'h8000_0010, 2'b00, 2'b00, 10'h0, 64'h0, 32'h8000_0010, 1'b0};
    vecs[3] = '{2'd0, 5'd5, 32'h11, 32'h0,  32'h0, 2'b11, 2'b00, {5'd5, 5'd5}, {32'h22, 32'h33}, 32'h33, 1'b1};
    vecs[4] = '{2'd0, 5'd5, 32'h11, 32'h0,  32'h0, 2'b10, 2'b00, {5'd5, 5'd5}, {32'h22, 32'h33}, 32'h22, 1'b1};
    vecs[5] = '{2'd0, 5'd0, 32'h0,  32'h0,  32'h0, 2'b01, 2'b00, {5'd0, 5'd0}, {32'h0, 32'hDEAD}, 32'h0, 1'b0};
    vecs[6] = '{2'd0, 5'd9, 32'h99, 32'h0,  32'h0, 2'b11, 2'b00, {5'd3, 5'd4}, {32'h1, 32'h2}, 32'h99, 1'b0};
    vecs[7] = '{2'd0, 5'd7, 32'h0,  32'h0,  32'h0, 2'b11, 2'b10, {5'd7, 5'd7}, {32'h71, 32'h70}, 32'h70, 1'b1};
    vecs[8] = '{2'd1, 5'd7, 32'h0,  32'h1234, 32'h0, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h70}, 32'h1234, 1'b0};

    reset = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    sel_i = 2'd0; rs2_addr_i = '0; rs2_data_i = '0; imm_i = '0; pc_i = '0;
    byp_valid_i = '0; byp_pending_i = '0; byp_addr_i = '0; byp_data_i = '0;
    step();
    step();
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_data", 64'(srcb_data_o), 64'd0);
    check("rst_hit", 64'(fwd_hit_o), 64'd0);
    step();
    reset = 1'b0;
    mon_en = 1'b1;

    // Back-to-back vectors at full throughput.
    for (int i = 0; i < 9; i++) issue($sformatf("vec%0d_ready", i), vecs[i], 1'b1);
    idle();
    idle();

    // Load-use stall on a pending youngest producer.
    v = '{2'd0, 5'd7, 32'h0, 32'h0, 32'h0, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h44}, 32'h44, 1'b1};
    for (int c = 0; c < 2; c++) begin
      issue("stall_ready", v, 1'b0);
      check("stall_no_load", 64'(out_valid_o), 64'd0);
    end
    v.bp = 2'b00;
    issue("release_ready", v, 1'b1);
    v.sel = 2'd1; v.bp = 2'b01; v.imm = 32'h5A5A; v.exp_d = 32'h5A5A; v.exp_h = 1'b0;
    issue("imm_ignores_pending", v, 1'b1);
    idle();
    idle();

    // Backpressure: hold 0xA for three cycles while a second request waits.
    v = '{2'd1, 5'd0, 32'h0, 32'hA, 32'h0, 2'b00, 2'b00, 10'h0, 64'h0, 32'hA, 1'b0};
    issue("bp_load", v, 1'b1);
    step();
    out_ready_i = 1'b0;
    v.imm = 32'hB;
    for (int c = 0; c < 3; c++) begin
      issue("bp_hold_ready", v, 1'b0);
      check("bp_hold_valid", 64'(out_valid_o), 64'd1);
      check("bp_hold_data", 64'(srcb_data_o), 64'hA);
    end
    // Flush the held entry with a request present.
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    void'(sb_q.pop_front());
    @(negedge clock);
    check("flush_kills_valid", 64'(out_valid_o), 64'd0);
    check("flush_keeps_data", 64'(srcb_data_o), 64'hA);
    out_ready_i = 1'b1;
    // Flush while the stage is ready: the request must be dropped.
    v.imm = 32'hC;
    step();
    flush_i = 1'b1;
    set_req(v);
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clock);
    check("flush_drops_req", 64'(out_valid_o), 64'd0);

    // Reset while a forwarded entry is held.
    v = '{2'd0, 5'd3, 32'h0, 32'h0, 32'h0, 2'b01, 2'b00, {5'd0, 5'd3}, {32'h0, 32'h55}, 32'h55, 1'b1};
    issue("rst_mid_load", v, 1'b1);
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ready", 64'(in_ready_o), 64'd0);
    step();
    reset = 1'b0;
    void'(sb_q.pop_front());
    @(negedge clock);
    check("rst_mid_valid", 64'(out_valid_o), 64'd0);
    check("rst_mid_data", 64'(srcb_data_o), 64'd0);
    check("rst_mid_hit", 64'(fwd_hit_o), 64'd0);
    out_ready_i = 1'b1;
    idle();
    idle();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
